// File: rtl/model_buffer_streamer_pkg.sv
// Shared render pipeline package: streamer FSM states and word-packing widths.
package model_buffer_streamer_pkg;

  // Every stored word carries three components, component 0 in the MSBs.
  localparam int unsigned COMPONENTS    = 3;
  localparam int unsigned DATAWIDTH_DEF = 24;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // Width of a packed {c0,c1,c2} word for a given component width.
  function automatic int unsigned word_width(input int unsigned comp_w);
    return COMPONENTS * comp_w;
  endfunction

endpackage

// File: rtl/model_buffer_streamer_if.sv
// Streamer bus: vertex/index read streams and memory load ports.
// slave modport faces the streamer, master modport faces the consumer/loader.
interface model_buffer_streamer_if
  import model_buffer_streamer_pkg::*;
#(
  parameter int unsigned DATAWIDTH          = 24,
  parameter int unsigned MAX_VERTEX_COUNT   = 16384,
  parameter int unsigned MAX_TRIANGLE_COUNT = 16384
);
  localparam int unsigned IW = $clog2(MAX_VERTEX_COUNT);
  localparam int unsigned TW = $clog2(MAX_TRIANGLE_COUNT);
  localparam int unsigned VW = word_width(DATAWIDTH);
  localparam int unsigned XW = word_width(IW);

  logic                 i_vertex_read_en;
  logic signed [VW-1:0] o_vertex;
  logic                 o_vertex_dv;
  logic                 o_vertex_last;

  logic                 i_index_read_en;
  logic [XW-1:0]        o_index_data;
  logic                 o_index_dv;
  logic                 o_index_last;

  logic                 vertex_wr_en;
  logic [IW-1:0]        vertex_wr_addr;
  logic [VW-1:0]        vertex_wr_data;
  logic                 index_wr_en;
  logic [TW-1:0]        index_wr_addr;
  logic [XW-1:0]        index_wr_data;

  modport slave (
    input  i_vertex_read_en, i_index_read_en,
    input  vertex_wr_en, vertex_wr_addr, vertex_wr_data,
    input  index_wr_en, index_wr_addr, index_wr_data,
    output o_vertex, o_vertex_dv, o_vertex_last,
    output o_index_data, o_index_dv, o_index_last
  );

  modport master (
    output i_vertex_read_en, i_index_read_en,
    output vertex_wr_en, vertex_wr_addr, vertex_wr_data,
    output index_wr_en, index_wr_addr, index_wr_data,
    input  o_vertex, o_vertex_dv, o_vertex_last,
    input  o_index_data, o_index_dv, o_index_last
  );

endinterface

// File: rtl/model_buffer_streamer_sam_bram_port.sv
// Sequential-access memory: simple dual-port read-first BRAM plus a cursor,
// remaining-word counter and last/complete tracking for one stream.
// Ports: clk, rst; wr_en/wr_addr/wr_data load port; load/base/count arm a
// stream; active gates reads; read_en -> rd_data/dv/last one cycle later;
// complete flags the stream as exhausted.
module sam_bram_port #(
  parameter  int unsigned DW    = 72,
  parameter  int unsigned DEPTH = 16384,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          active,
  input  logic          read_en,
  output logic [DW-1:0] rd_data,
  output logic          dv,
  output logic          last,
  output logic          complete
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] cursor;
  logic [AW:0]   remain;
  logic          accept_c;

  assign accept_c = active && read_en && !complete;

  // Write port; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port and stream bookkeeping; mem read here sees pre-write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor   <= '0;
      remain   <= '0;
      complete <= 1'b1;
      dv       <= 1'b0;
      last     <= 1'b0;
      rd_data  <= '0;
    end else begin
      dv   <= 1'b0;
      last <= 1'b0;
      if (load) begin
        cursor   <= base;
        remain   <= count;
        complete <= (count == '0);
      end else if (accept_c) begin
        rd_data  <= mem[cursor];
        dv       <= 1'b1;
        last     <= (remain == (AW+1)'(1));
        complete <= (remain == (AW+1)'(1));
        remain   <= remain - (AW+1)'(1);
        // Wrap explicitly so non-power-of-two depths also wrap correctly.
        cursor   <= (cursor == AW'(DEPTH - 1)) ? '0 : cursor + AW'(1);
      end
    end
  end

endmodule

// File: rtl/model_buffer_streamer.sv
// Streams one model's vertex and index buffers out of on-chip memory.
// Ports: clk, rst (sync, active-high); start/ready handshake; vertex_base,
// vertex_count, index_base, triangle_count latched on start; done pulses on
// return to IDLE; bus carries both read streams and both load ports.
module model_buffer_streamer
  import model_buffer_streamer_pkg::*;
#(
  parameter  int unsigned DATAWIDTH          = 24,
  parameter  int unsigned MAX_VERTEX_COUNT   = 16384,
  parameter  int unsigned MAX_TRIANGLE_COUNT = 16384,
  localparam int unsigned IW                 = $clog2(MAX_VERTEX_COUNT),
  localparam int unsigned TW                 = $clog2(MAX_TRIANGLE_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  input  logic [IW-1:0]           vertex_base,
  input  logic [IW:0]             vertex_count,
  input  logic [TW-1:0]           index_base,
  input  logic [TW:0]             triangle_count,
  output logic                    done,
  model_buffer_streamer_if.slave  bus
);

  localparam int unsigned VW = word_width(DATAWIDTH);
  localparam int unsigned XW = word_width(IW);

  stream_state_e state;
  logic          load_c;
  logic          active_c;
  logic          v_complete;
  logic          i_complete;

  assign load_c   = (state == ST_IDLE) && start;
  assign active_c = (state == ST_STREAM);

  // Control FSM; start is only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_STREAM;
            ready <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (v_complete && i_complete) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  sam_bram_port #(.DW(VW), .DEPTH(MAX_VERTEX_COUNT)) u_vertex (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.vertex_wr_en),
    .wr_addr  (bus.vertex_wr_addr),
    .wr_data  (bus.vertex_wr_data),
    .load     (load_c),
    .base     (vertex_base),
    .count    (vertex_count),
    .active   (active_c),
    .read_en  (bus.i_vertex_read_en),
    .rd_data  (bus.o_vertex),
    .dv       (bus.o_vertex_dv),
    .last     (bus.o_vertex_last),
    .complete (v_complete)
  );

  sam_bram_port #(.DW(XW), .DEPTH(MAX_TRIANGLE_COUNT)) u_index (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.index_wr_en),
    .wr_addr  (bus.index_wr_addr),
    .wr_data  (bus.index_wr_data),
    .load     (load_c),
    .base     (index_base),
    .count    (triangle_count),
    .active   (active_c),
    .read_en  (bus.i_index_read_en),
    .rd_data  (bus.o_index_data),
    .dv       (bus.o_index_dv),
    .last     (bus.o_index_last),
    .complete (i_complete)
  );

endmodule

// File: tb/tb_model_buffer_streamer.sv
// Directed bench for model_buffer_streamer: a vector table for the basic
// dual-stream case plus hand sequences for reset, zero count, wrap,
// read-first collision and ignored start.
module tb_model_buffer_streamer;

  localparam int unsigned DW = 24;
  localparam int unsigned NV = 8;
  localparam int unsigned NT = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned TW = 3;
  localparam int unsigned VW = 3 * DW;
  localparam int unsigned XW = 3 * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic          done;
  logic [IW-1:0] vertex_base;
  logic [IW:0]   vertex_count;
  logic [TW-1:0] index_base;
  logic [TW:0]   triangle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  model_buffer_streamer_if #(
    .DATAWIDTH(DW), .MAX_VERTEX_COUNT(NV), .MAX_TRIANGLE_COUNT(NT)
  ) bus ();

  model_buffer_streamer #(
    .DATAWIDTH(DW), .MAX_VERTEX_COUNT(NV), .MAX_TRIANGLE_COUNT(NT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ready          (ready),
    .vertex_base    (vertex_base),
    .vertex_count   (vertex_count),
    .index_base     (index_base),
    .triangle_count (triangle_count),
    .done           (done),
    .bus            (bus)
  );

  typedef struct {
    logic          vre;
    logic          ire;
    logic          v_dv;
    logic          v_last;
    logic [VW-1:0] v_data;
    logic          i_dv;
    logic          i_last;
    logic [XW-1:0] i_data;
    logic          rdy;
    logic          dn;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [VW-1:0] vword(input int i);
    return {24'(i + 1), 24'(i + 100), 24'(i + 200)};
  endfunction

  function automatic logic [XW-1:0] tword(input int a, input int b, input int c);
    return {3'(a), 3'(b), 3'(c)};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int vb, input int vc, input int ib, input int tc);
    vertex_base    = IW'(vb);
    vertex_count   = (IW+1)'(vc);
    index_base     = TW'(ib);
    triangle_count = (TW+1)'(tc);
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    start                = 1'b0;
    vertex_base          = '0;
    vertex_count         = '0;
    index_base           = '0;
    triangle_count       = '0;
    bus.i_vertex_read_en = 1'b0;
    bus.i_index_read_en  = 1'b0;
    bus.vertex_wr_en     = 1'b0;
    bus.vertex_wr_addr   = '0;
    bus.vertex_wr_data   = '0;
    bus.index_wr_en      = 1'b0;
    bus.index_wr_addr    = '0;
    bus.index_wr_data    = '0;
    step();
    step();

    chk1("rst_ready", ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_vdv", bus.o_vertex_dv, 1'b0);
    chk1("rst_idv", bus.o_index_dv, 1'b0);
    chkw("rst_vdata", bus.o_vertex, '0);
    rst = 1'b0;

    // Load memories.
    for (int i = 0; i < int'(NV); i++) begin
      bus.vertex_wr_en   = 1'b1;
      bus.vertex_wr_addr = IW'(i);
      bus.vertex_wr_data = vword(i);
      step();
    end
    bus.vertex_wr_en  = 1'b0;
    bus.index_wr_en   = 1'b1;
    bus.index_wr_addr = TW'(0);
    bus.index_wr_data = tword(0, 1, 2);
    step();
    bus.index_wr_addr = TW'(1);
    bus.index_wr_data = tword(2, 3, 0);
    step();
    bus.index_wr_en   = 1'b0;

    // Vertices base 1 count 3 held read; triangles count 2 read every other cycle.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, vword(1), 1'b1, 1'b0, tword(0,1,2), 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, vword(2), 1'b0, 1'b0, tword(0,1,2), 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, vword(3), 1'b1, 1'b1, tword(2,3,0), 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, vword(3), 1'b0, 1'b0, tword(2,3,0), 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, vword(3), 1'b0, 1'b0, tword(2,3,0), 1'b1, 1'b0};

    do_start(1, 3, 0, 2);
    chk1("a_ready_low", ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.i_vertex_read_en = tbl[k].vre;
      bus.i_index_read_en  = tbl[k].ire;
      step();
      chk1($sformatf("vec%0d_vdv", k), bus.o_vertex_dv, tbl[k].v_dv);
      chk1($sformatf("vec%0d_vlast", k), bus.o_vertex_last, tbl[k].v_last);
      chkw($sformatf("vec%0d_vdata", k), bus.o_vertex, tbl[k].v_data);
      chk1($sformatf("vec%0d_idv", k), bus.o_index_dv, tbl[k].i_dv);
      chk1($sformatf("vec%0d_ilast", k), bus.o_index_last, tbl[k].i_last);
      chkw($sformatf("vec%0d_idata", k), VW'(bus.o_index_data), VW'(tbl[k].i_data));
      chk1($sformatf("vec%0d_ready", k), ready, tbl[k].rdy);
      chk1($sformatf("vec%0d_done", k), done, tbl[k].dn);
    end
    bus.i_vertex_read_en = 1'b0;
    bus.i_index_read_en  = 1'b0;

    // Zero vertex count: only the single index word is delivered.
    do_start(0, 0, 1, 1);
    bus.i_vertex_read_en = 1'b1;
    bus.i_index_read_en  = 1'b1;
    step();
    chk1("b_vdv", bus.o_vertex_dv, 1'b0);
    chk1("b_vlast", bus.o_vertex_last, 1'b0);
    chk1("b_idv", bus.o_index_dv, 1'b1);
    chk1("b_ilast", bus.o_index_last, 1'b1);
    chkw("b_idata", VW'(bus.o_index_data), VW'(tword(2, 3, 0)));
    chk1("b_done_early", done, 1'b0);
    bus.i_index_read_en = 1'b0;
    step();
    chk1("b_vdv2", bus.o_vertex_dv, 1'b0);
    chk1("b_done", done, 1'b1);
    chk1("b_ready", ready, 1'b1);
    bus.i_vertex_read_en = 1'b0;
    step();
    chk1("b_done_once", done, 1'b0);

    // Reset mid-stream after two of five reads, then restart from base.
    do_start(0, 5, 0, 0);
    bus.i_vertex_read_en = 1'b1;
    step();
    chkw("c_rd0", bus.o_vertex, vword(0));
    step();
    chkw("c_rd1", bus.o_vertex, vword(1));
    rst = 1'b1;
    step();
    chk1("c_rst_vdv", bus.o_vertex_dv, 1'b0);
    chk1("c_rst_ready", ready, 1'b1);
    chk1("c_rst_done", done, 1'b0);
    chkw("c_rst_vdata", bus.o_vertex, '0);
    rst = 1'b0;
    bus.i_vertex_read_en = 1'b0;
    do_start(0, 5, 0, 0);
    bus.i_vertex_read_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk1($sformatf("c_re%0d_vdv", k), bus.o_vertex_dv, 1'b1);
      chkw($sformatf("c_re%0d_vdata", k), bus.o_vertex, vword(k));
      chk1($sformatf("c_re%0d_vlast", k), bus.o_vertex_last, k == 4);
    end
    step();
    chk1("c_done", done, 1'b1);
    chk1("c_vdv_after", bus.o_vertex_dv, 1'b0);
    bus.i_vertex_read_en = 1'b0;

    // Cursor wraps past the top of the vertex memory.
    do_start(6, 3, 0, 0);
    bus.i_vertex_read_en = 1'b1;
    step();
    chkw("w_rd6", bus.o_vertex, vword(6));
    step();
    chkw("w_rd7", bus.o_vertex, vword(7));
    step();
    chkw("w_rd0", bus.o_vertex, vword(0));
    chk1("w_last", bus.o_vertex_last, 1'b1);
    step();
    chk1("w_done", done, 1'b1);
    bus.i_vertex_read_en = 1'b0;

    // Same-cycle write and read of address 2 returns the old word.
    do_start(2, 2, 0, 0);
    bus.i_vertex_read_en = 1'b1;
    bus.vertex_wr_en     = 1'b1;
    bus.vertex_wr_addr   = IW'(2);
    bus.vertex_wr_data   = VW'(12'h123);
    step();
    bus.vertex_wr_en = 1'b0;
    chkw("d_old", bus.o_vertex, vword(2));
    step();
    chkw("d_rd3", bus.o_vertex, vword(3));
    chk1("d_last", bus.o_vertex_last, 1'b1);
    bus.i_vertex_read_en = 1'b0;
    step();
    chk1("d_done", done, 1'b1);
    do_start(2, 1, 0, 0);
    bus.i_vertex_read_en = 1'b1;
    step();
    chkw("d_new", bus.o_vertex, VW'(12'h123));
    bus.i_vertex_read_en = 1'b0;
    step();
    chk1("d_done2", done, 1'b1);

    // Start pulsed mid-stream with different bases/counts is ignored.
    do_start(0, 2, 0, 0);
    vertex_base    = IW'(5);
    vertex_count   = (IW+1)'(1);
    triangle_count = (TW+1)'(1);
    start          = 1'b1;
    step();
    start          = 1'b0;
    chk1("e_ready", ready, 1'b0);
    chk1("e_vdv", bus.o_vertex_dv, 1'b0);
    bus.i_vertex_read_en = 1'b1;
    step();
    chkw("e_rd0", bus.o_vertex, vword(0));
    chk1("e_last0", bus.o_vertex_last, 1'b0);
    step();
    chkw("e_rd1", bus.o_vertex, vword(1));
    chk1("e_last1", bus.o_vertex_last, 1'b1);
    bus.i_vertex_read_en = 1'b0;
    step();
    chk1("e_done", done, 1'b1);
    chk1("e_idv", bus.o_index_dv, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
